branch_resolve_queue: RTL and testbench

//  Tracks in-flight conditional branches between fetch and execute.

---
 rtl/branch_resolve_queue_if.sv | 47 ++++
 rtl/branch_resolve_queue.sv | 111 +++++++++++
 tb/tb_branch_resolve_queue.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/BHT-update signal bundle for the branch resolve queue.
// The master side (fetch and execute) drives pushes and resolves.
// The slave side (the queue) drives status, redirect and BHT-update outputs.
interface branch_resolve_queue_if #(
  parameter int DEPTH       = 4,
  parameter int table_width = 3,
  parameter int XLEN        = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  // fetch side
  logic                   F_Push;
  logic [XLEN-1:0]        F_PC;
  logic                   F_PredictTaken;
  logic                   F_Full;
  // execute side
  logic                   EX_Resolve;
  logic                   EX_BranchTaken;
  logic [XLEN-1:0]        EX_Target;
  // flush / redirect
  logic                   Mispredict;
  logic [XLEN-1:0]        Redirect_PC;
  // BHT training strobe
  logic [table_width-1:0] JB_PC_Slice;
  logic                   JB_BranchTaken;
  logic                   JB_AttemptBranch;
  // status
  logic [CW-1:0]          Q_Count;
  logic                   Q_Empty;
  logic                   Err_Underflow;

  modport master (
    output F_Push, F_PC, F_PredictTaken,
    output EX_Resolve, EX_BranchTaken, EX_Target,
    input  F_Full, Mispredict, Redirect_PC,
    input  JB_PC_Slice, JB_BranchTaken, JB_AttemptBranch,
    input  Q_Count, Q_Empty, Err_Underflow
  );

  modport slave (
    input  F_Push, F_PC, F_PredictTaken,
    input  EX_Resolve, EX_BranchTaken, EX_Target,
    output F_Full, Mispredict, Redirect_PC,
    output JB_PC_Slice, JB_BranchTaken, JB_AttemptBranch,
    output Q_Count, Q_Empty, Err_Underflow
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight conditional branches. Fetch pushes PC and
// predicted direction; execute resolves the oldest entry. A wrong
// prediction raises a one-cycle flush with the corrected fetch PC and drops
// every younger (wrong-path) entry. Every valid resolve also produces a
// one-cycle BHT training strobe.
module branch_resolve_queue #(
  parameter int DEPTH       = 4,
  parameter int table_width = 3,
  parameter int XLEN        = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  branch_resolve_queue_if.slave     bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  // entry storage; contents are meaningless until written, so no reset
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic            pred_mem [DEPTH];

  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]   count_reg, count_next;

  logic                   mispredict_reg;
  logic [XLEN-1:0]        redirect_reg;
  logic [table_width-1:0] jb_slice_reg;
  logic                   jb_taken_reg;
  logic                   jb_attempt_reg;
  logic                   err_reg;

  logic            full, empty;
  logic            resolve_ok, push_ok, mispred;
  logic [XLEN-1:0] head_pc;
  logic            head_pred;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

  assign head_pc   = pc_mem[rd_ptr_reg];
  assign head_pred = pred_mem[rd_ptr_reg];

  // A resolve frees the head slot this cycle, so a push at full still fits;
  // a push coinciding with a mispredict is wrong-path and is dropped.
  assign resolve_ok = bus.EX_Resolve && !empty;
  assign mispred    = resolve_ok && (head_pred != bus.EX_BranchTaken);
  assign push_ok    = bus.F_Push && (!full || resolve_ok) && !mispred;

  // next-state for pointers and occupancy
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (mispred) begin
      // flush: everything behind the head is wrong-path
      rd_ptr_next = wr_ptr_reg;
      count_next  = '0;
    end else begin
      if (resolve_ok) rd_ptr_next = rd_ptr_reg + PW'(1);
      if (push_ok)    wr_ptr_next = wr_ptr_reg + PW'(1);
      if (push_ok && !resolve_ok)      count_next = count_reg + CW'(1);
      else if (!push_ok && resolve_ok) count_next = count_reg - CW'(1);
    end
  end

  // write accepted branches into the slot at the write pointer
  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[wr_ptr_reg]   <= bus.F_PC;
      pred_mem[wr_ptr_reg] <= bus.F_PredictTaken;
    end
  end

  // queue bookkeeping and registered resolve outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      mispredict_reg <= 1'b0;
      redirect_reg   <= '0;
      jb_slice_reg   <= '0;
      jb_taken_reg   <= 1'b0;
      jb_attempt_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      rd_ptr_reg     <= rd_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      count_reg      <= count_next;
      mispredict_reg <= mispred;
      jb_attempt_reg <= resolve_ok;
      jb_taken_reg   <= resolve_ok && bus.EX_BranchTaken;
      jb_slice_reg   <= resolve_ok ? head_pc[table_width+1:2] : '0;
      if (mispred)
        redirect_reg <= bus.EX_BranchTaken ? bus.EX_Target : head_pc + XLEN'(4);
      if (bus.EX_Resolve && empty)
        err_reg <= 1'b1;
    end
  end

  assign bus.F_Full           = full;
  assign bus.Q_Empty          = empty;
  assign bus.Q_Count          = count_reg;
  assign bus.Mispredict       = mispredict_reg;
  assign bus.Redirect_PC      = redirect_reg;
  assign bus.JB_PC_Slice      = jb_slice_reg;
  assign bus.JB_BranchTaken   = jb_taken_reg;
  assign bus.JB_AttemptBranch = jb_attempt_reg;
  assign bus.Err_Underflow    = err_reg;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: a directed vector table with explicit
// expectations, randomized traffic against a queue-based reference model,
// and an asynchronous reset applied in the middle of a pending flush.
module tb_branch_resolve_queue;
  localparam int DEPTH = 4;
  localparam int TW    = 3;
  localparam int XLEN  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_queue_if #(.DEPTH(DEPTH), .table_width(TW), .XLEN(XLEN)) bus ();

  branch_resolve_queue #(.DEPTH(DEPTH), .table_width(TW), .XLEN(XLEN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: a plain queue of branches plus expected output registers
  typedef struct {
    logic [31:0] pc;
    logic        pred;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_redirect = '0;
  logic        m_err  = 1'b0;
  logic        m_att  = 1'b0;
  logic [2:0]  m_slice = '0;
  logic        m_jbt  = 1'b0;
  logic        m_misp = 1'b0;

  typedef struct {
    logic        push;
    logic [31:0] pc;
    logic        pred;
    logic        res;
    logic        taken;
    logic [31:0] tgt;
    int          cnt;
    logic        misp;
    logic [31:0] redir;
    logic        att;
    logic [2:0]  slice;
    logic        jbt;
    logic        err;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(logic push, logic [31:0] pc, logic pred, logic res,
                              logic taken, logic [31:0] tgt, int cnt, logic misp,
                              logic [31:0] redir, logic att, logic [2:0] slice,
                              logic jbt, logic err);
    vec_t v;
    v.push = push; v.pc = pc; v.pred = pred; v.res = res; v.taken = taken;
    v.tgt = tgt; v.cnt = cnt; v.misp = misp; v.redir = redir; v.att = att;
    v.slice = slice; v.jbt = jbt; v.err = err;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_redirect = '0; m_err = 1'b0; m_att = 1'b0;
    m_slice = '0; m_jbt = 1'b0; m_misp = 1'b0;
  endtask

  // one clock of traffic: drive, advance the model, check every output
  task automatic cycle(input logic push, input logic [31:0] pc, input logic pred,
                       input logic res, input logic taken, input logic [31:0] tgt);
    int   n;
    ent_t h;
    ent_t e;
    bus.F_Push = push; bus.F_PC = pc; bus.F_PredictTaken = pred;
    bus.EX_Resolve = res; bus.EX_BranchTaken = taken; bus.EX_Target = tgt;

    n = mq.size();
    e.pc = pc; e.pred = pred;
    m_att = 1'b0; m_slice = '0; m_jbt = 1'b0; m_misp = 1'b0;
    if (res && n == 0) m_err = 1'b1;
    if (res && n != 0) begin
      h = mq.pop_front();
      m_att = 1'b1; m_slice = h.pc[4:2]; m_jbt = taken;
      if (h.pred != taken) begin
        m_misp = 1'b1;
        m_redirect = taken ? tgt : h.pc + 32'd4;
        mq.delete();
      end else if (push) begin
        mq.push_back(e);
      end
    end else if (push && n < DEPTH) begin
      mq.push_back(e);
    end

    @(posedge clk);
    #1;
    cyc++;
    chk("count",    32'(bus.Q_Count),       32'(mq.size()));
    chk("empty",    32'(bus.Q_Empty),       32'(mq.size() == 0));
    chk("full",     32'(bus.F_Full),        32'(mq.size() == DEPTH));
    chk("misp",     32'(bus.Mispredict),    32'(m_misp));
    chk("redirect", bus.Redirect_PC,        m_redirect);
    chk("attempt",  32'(bus.JB_AttemptBranch), 32'(m_att));
    chk("slice",    32'(bus.JB_PC_Slice),   32'(m_slice));
    chk("jbtaken",  32'(bus.JB_BranchTaken), 32'(m_jbt));
    chk("err",      32'(bus.Err_Underflow), 32'(m_err));
    $display("cyc %0d push=%b pc=%h pred=%b res=%b tk=%b tgt=%h | cnt=%0d misp=%b rdr=%h att=%b sl=%0d jbt=%b err=%b",
             cyc, push, pc, pred, res, taken, tgt, bus.Q_Count, bus.Mispredict,
             bus.Redirect_PC, bus.JB_AttemptBranch, bus.JB_PC_Slice,
             bus.JB_BranchTaken, bus.Err_Underflow);
  endtask

  initial begin
    logic [31:0] rpc;
    logic        tk;

    bus.F_Push = 0; bus.F_PC = '0; bus.F_PredictTaken = 0;
    bus.EX_Resolve = 0; bus.EX_BranchTaken = 0; bus.EX_Target = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state held over three idle cycles
    repeat (3) cycle(0, '0, 0, 0, 0, '0);
    chk("rst_empty", 32'(bus.Q_Empty), 32'd1);
    chk("rst_full",  32'(bus.F_Full),  32'd0);

    // five back-to-back pushes, fifth dropped; four correct resolves in order
    for (int i = 0; i < 5; i++)
      add(1, 32'h10 + 32'(4 * i), 1, 0, 0, '0, (i < 4) ? i + 1 : 4, 0, '0, 0, '0, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, '0, 0, 1, 1, '0, 3 - i, 0, '0, 1, 3'(4 + i), 1, 0);
    // single correctly predicted taken branch
    add(1, 32'h100, 1, 0, 0, '0,     1, 0, '0, 0, 3'd0, 0, 0);
    add(0, '0,      0, 1, 1, 32'h40, 0, 0, '0, 1, 3'd0, 1, 0);
    // mispredicted taken head flushes three entries; same-cycle push lost
    add(1, 32'h104, 0, 0, 0, '0,      1, 0, '0,      0, 3'd0, 0, 0);
    add(1, 32'h200, 1, 0, 0, '0,      2, 0, '0,      0, 3'd0, 0, 0);
    add(1, 32'h300, 1, 0, 0, '0,      3, 0, '0,      0, 3'd0, 0, 0);
    add(1, 32'h400, 1, 1, 1, 32'h800, 0, 1, 32'h800, 1, 3'd1, 1, 0);
    // predicted taken, actually not taken: redirect to fall-through
    add(1, 32'h104, 1, 0, 0, '0,      1, 0, 32'h800, 0, 3'd0, 0, 0);
    add(0, '0,      0, 1, 0, 32'h999, 0, 1, 32'h108, 1, 3'd1, 0, 0);
    // resolve on empty: no strobe, sticky error
    add(0, '0, 0, 1, 1, 32'h50, 0, 0, 32'h108, 0, 3'd0, 0, 1);
    // fill, then six push+correct-resolve cycles at full wrap the pointers
    for (int i = 0; i < 4; i++)
      add(1, 32'h20 + 32'(4 * i), 0, 0, 0, '0, i + 1, 0, 32'h108, 0, 3'd0, 0, 1);
    for (int i = 0; i < 6; i++)
      add(1, 32'h30 + 32'(4 * i), 0, 1, 0, '0, 4, 0, 32'h108, 1, 3'(i), 0, 1);
    for (int i = 0; i < 4; i++)
      add(0, '0, 0, 1, 0, '0, 3 - i, 0, 32'h108, 1, 3'(6 + i), 0, 1);
    // push + correct resolve at count==1
    add(1, 32'h60, 1, 0, 0, '0, 1, 0, 32'h108, 0, 3'd0, 0, 1);
    add(1, 32'h64, 1, 1, 1, '0, 1, 0, 32'h108, 1, 3'd0, 1, 1);
    add(0, '0,     0, 1, 1, '0, 0, 0, 32'h108, 1, 3'd1, 1, 1);

    foreach (vecs[i]) begin
      cycle(vecs[i].push, vecs[i].pc, vecs[i].pred, vecs[i].res, vecs[i].taken, vecs[i].tgt);
      chk("v_count",    32'(bus.Q_Count),          32'(vecs[i].cnt));
      chk("v_misp",     32'(bus.Mispredict),       32'(vecs[i].misp));
      chk("v_redirect", bus.Redirect_PC,           vecs[i].redir);
      chk("v_attempt",  32'(bus.JB_AttemptBranch), 32'(vecs[i].att));
      chk("v_slice",    32'(bus.JB_PC_Slice),      32'(vecs[i].slice));
      chk("v_jbtaken",  32'(bus.JB_BranchTaken),   32'(vecs[i].jbt));
      chk("v_err",      32'(bus.Err_Underflow),    32'(vecs[i].err));
    end

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      rpc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      cycle($urandom_range(0, 9) < 6, rpc, 1'($urandom), $urandom_range(0, 9) < 5,
            1'($urandom), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
    end

    // fill to four, then assert reset while a mispredicting resolve is pending
    repeat (4) cycle(1, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 1'($urandom), 0, 0, '0);
    tk = !mq[0].pred;
    bus.F_Push = 0; bus.EX_Resolve = 1; bus.EX_BranchTaken = tk; bus.EX_Target = 32'h1234;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_count",    32'(bus.Q_Count),          32'd0);
    chk("arst_empty",    32'(bus.Q_Empty),          32'd1);
    chk("arst_full",     32'(bus.F_Full),           32'd0);
    chk("arst_redirect", bus.Redirect_PC,           32'd0);
    chk("arst_err",      32'(bus.Err_Underflow),    32'd0);
    chk("arst_attempt",  32'(bus.JB_AttemptBranch), 32'd0);
    @(posedge clk);
    #1;
    chk("arst_misp",     32'(bus.Mispredict),       32'd0);
    chk("arst_attempt2", 32'(bus.JB_AttemptBranch), 32'd0);
    rst = 1'b0;
    bus.EX_Resolve = 0;
    cycle(1, 32'h700, 0, 0, 0, '0);
    cycle(0, '0, 0, 1, 1, 32'hA00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
